mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
Parametrised iterative multiply/divide unit implementing the RV32M/RV64M integer operations, width set by XLEN.
Sits beside the combinational ALU in the execute stage. Operands enter over a valid/ready handshake and the result leaves over a second valid/ready handshake.
Uses one shift-add / restoring-divide iteration per cycle, with a single-cycle fast path for divide special cases and a pipeline kill input.

Parameters:
XLEN, 32, operand/result width (32 or 64)
CNT_W, $clog2(XLEN), width of the iteration counter (derived, not overridden)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset; asynchronous, active-high
i_valid  in  1  request valid
o_ready  out  1  unit can accept a request (IDLE only)
i_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_Ra  in  XLEN  rs1 operand
i_Rb  in  XLEN  rs2 operand
i_kill  in  1  flush: abandon any in-flight or unconsumed operation
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_Rc  out  XLEN  result
o_Z  out  1  o_Rc == 0 (meaningful only while o_valid)
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_rst=1): state=IDLE; o_valid=0; o_Rc=0; counter=0; o_ready=1; o_busy=0.
- FSM states:
  - IDLE: o_ready=1. A request is accepted on an edge where i_valid & o_ready & !i_kill.
    - Divide special case: go to DONE.
    - Otherwise: go to CALC, counter=XLEN-1.
  - CALC: one iteration per cycle. At counter==0 the edge writes the sign-corrected result into o_Rc and goes to DONE. Otherwise counter decrements.
  - DONE: o_valid=1, o_Rc held stable. On an edge with i_ready=1, go to IDLE and clear o_valid. No new request is accepted in the same cycle as result hand-off.
- i_kill=1 at an edge in any state: next state IDLE, o_valid=0, result discarded. i_kill has priority over accept and over completion.
- Latency, with accept at edge N:
  - Normal ops: o_valid high from edge N+XLEN+1.
  - Special cases: o_valid high from edge N+1.
  - Throughput: one operation per XLEN+2 cycles at best.
- Sign handling:
  - At accept, the signed operands are converted to magnitudes:
    - MUL/MULH/DIV/REM: both operands.
    - MULHSU: i_Ra only.
  - Result sign: for products and quotients, negate when the operand signs differ. For REM, the remainder takes the dividend's sign.
  - MUL returns the low XLEN bits of the 2*XLEN product. MULH/MULHSU/MULHU return the high XLEN bits.
  - All arithmetic is modulo 2^XLEN with no exceptions.
- Divide special cases (fast path):
  - Divisor==0:
    - DIV/DIVU: quotient = all ones.
    - REM/REMU: result = i_Ra.
  - Signed overflow (i_Ra = 1<<(XLEN-1), i_Rb = all ones, DIV/REM):
    - DIV: quotient = i_Ra.
    - REM: result = 0.
- Operands are captured at accept. i_Ra, i_Rb and i_op are don't-care afterwards.
- Reset asserted mid-operation: immediate return to the reset values, with no output glitch beyond the async clear.
- i_valid asserted while busy is ignored; the requester must hold it until o_ready.

Decomposition:
- Package mdu_pkg:
  - mdu_op_e enum: 3-bit funct3 encodings.
  - mdu_state_e enum: IDLE, CALC, DONE.
  - Helpers is_div(op), is_signed_a(op), is_signed_b(op).
- Sub-module mdu_step (combinational): one iteration.
  - Multiply: conditional add of the multiplicand into the high half, then right shift of {acc, multiplier}.
  - Divide: left shift of {rem, quotient}, trial subtract of the divisor, restore on borrow.
  - Instantiated once, shared by both op classes.

Test Plan (XLEN=32):
- MUL 7 * 0xFFFFFFFD -> o_Rc=0xFFFFFFEB, o_valid rises exactly 33 edges after the accept edge; MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2, o_Z=0; REMU 14/7 -> 0 with o_Z=1.
- Special cases, each with o_valid at edge N+1: DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid -> o_valid, o_Rc and o_Z stable and o_ready=0 throughout; the result is consumed on the first i_ready=1 edge, and o_ready=1 the next cycle.
- i_kill pulsed at CALC iteration 5, and separately in DONE -> IDLE next edge, o_valid never asserted or dropped, a subsequent DIVU 9/3 returns 3 correctly.
- i_rst pulsed asynchronously mid-CALC, between clock edges -> o_valid=0, o_ready=1, o_Rc=0 immediately; a following MUL 3*4 returns 12.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

   // RV32M/RV64M funct3 encodings
   typedef enum logic [2:0] {
      OpMul    = 3'd0,
      OpMulh   = 3'd1,
      OpMulhsu = 3'd2,
      OpMulhu  = 3'd3,
      OpDiv    = 3'd4,
      OpDivu   = 3'd5,
      OpRem    = 3'd6,
      OpRemu   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } mdu_state_e;

   function automatic logic is_div(input mdu_op_e op);
      return op[2];
   endfunction

   function automatic logic is_signed_a(input mdu_op_e op);
      return (op == OpMul) || (op == OpMulh) || (op == OpMulhsu) ||
             (op == OpDiv) || (op == OpRem);
   endfunction

   function automatic logic is_signed_b(input mdu_op_e op);
      return (op == OpMul) || (op == OpMulh) || (op == OpDiv) || (op == OpRem);
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One shift-add multiply or restoring-divide iteration on unsigned magnitudes.
module mdu_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic            div,
   input  logic [XLEN-1:0] acc,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] opb,
   output logic [XLEN-1:0] acc_nx,
   output logic [XLEN-1:0] lo_nx
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // Multiply: {acc,lo} holds partial product and remaining multiplier bits.
   // Divide: {acc,lo} holds partial remainder and quotient being shifted in.
   always_comb begin
      sum     = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
      shifted = {acc, lo[XLEN-1]};
      // partial remainder < divisor, so diff[XLEN] is exactly the borrow
      diff    = shifted - {1'b0, opb};
      if (div) begin
         if (!diff[XLEN]) begin
            acc_nx = diff[XLEN-1:0];
            lo_nx  = {lo[XLEN-2:0], 1'b1};
         end else begin
            acc_nx = shifted[XLEN-1:0];
            lo_nx  = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         acc_nx = sum[XLEN:1];
         lo_nx  = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready in and out.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_Ra,
   input  logic [XLEN-1:0] i_Rb,
   input  logic            i_kill,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_Rc,
   output logic            o_Z,
   output logic            o_busy
);

   localparam int unsigned CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, opb_q, opb_d, rc_q, rc_d;
   logic            div_q, div_d, hi_q, hi_d, neg_q, neg_d;

   mdu_op_e         op;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN-1:0] acc_nx, lo_nx, fixed;

   assign op = mdu_op_e'(i_op);

   mdu_step #(
      .XLEN (XLEN)
   ) u_step (
      .div    (div_q),
      .acc    (acc_q),
      .lo     (lo_q),
      .opb    (opb_q),
      .acc_nx (acc_nx),
      .lo_nx  (lo_nx)
   );

   // Operand magnitudes and sign-corrected final result.
   always_comb begin
      a_neg = is_signed_a(op) & i_Ra[XLEN-1];
      b_neg = is_signed_b(op) & i_Rb[XLEN-1];
      a_mag = a_neg ? -i_Ra : i_Ra;
      b_mag = b_neg ? -i_Rb : i_Rb;
      if (div_q) begin
         fixed = hi_q ? acc_nx : lo_nx;
         if (neg_q) fixed = -fixed;
      end else if (hi_q) begin
         // high half of the negated 2*XLEN product: carry in only if low half is zero
         fixed = neg_q ? (~acc_nx + XLEN'(lo_nx == '0)) : acc_nx;
      end else begin
         fixed = neg_q ? -lo_nx : lo_nx;
      end
   end

   // Next-state and datapath control; kill overrides everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      opb_d   = opb_q;
      rc_d    = rc_q;
      div_d   = div_q;
      hi_d    = hi_q;
      neg_d   = neg_q;
      unique case (state_q)
         StIdle: begin
            if (i_valid && !i_kill) begin
               if (is_div(op) && (i_Rb == '0)) begin
                  rc_d    = op[1] ? i_Ra : '1;
                  state_d = StDone;
               end else if (is_div(op) && !op[0] && (i_Ra == MinNeg) && (i_Rb == '1)) begin
                  rc_d    = op[1] ? '0 : i_Ra;
                  state_d = StDone;
               end else begin
                  state_d = StCalc;
                  cnt_d   = CNT_W'(XLEN - 1);
                  acc_d   = '0;
                  div_d   = is_div(op);
                  lo_d    = is_div(op) ? a_mag : b_mag;
                  opb_d   = is_div(op) ? b_mag : a_mag;
                  hi_d    = is_div(op) ? op[1] : (op != OpMul);
                  neg_d   = (is_div(op) && op[1]) ? a_neg : (a_neg ^ b_neg);
               end
            end
         end
         StCalc: begin
            acc_d = acc_nx;
            lo_d  = lo_nx;
            if (cnt_q == '0) begin
               rc_d    = fixed;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StDone: begin
            if (i_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (i_kill) state_d = StIdle;
   end

   // State and datapath registers, asynchronously cleared.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         opb_q   <= '0;
         rc_q    <= '0;
         div_q   <= 1'b0;
         hi_q    <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         opb_q   <= opb_d;
         rc_q    <= rc_d;
         div_q   <= div_d;
         hi_q    <= hi_d;
         neg_q   <= neg_d;
      end
   end

   assign o_ready = (state_q == StIdle);
   assign o_busy  = (state_q != StIdle);
   assign o_valid = (state_q == StDone);
   assign o_Rc    = rc_q;
   assign o_Z     = (rc_q == '0);

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=32): vector table, random ops, corner sequences.
module tb_mdu_iter;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [2:0]  i_op = '0;
   logic [31:0] i_Ra = '0;
   logic [31:0] i_Rb = '0;
   logic        i_kill = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_Rc;
   logic        o_Z;
   logic        o_busy;

   int n_pass = 0;
   int n_total = 0;

   mdu_iter #(
      .XLEN (32)
   ) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_op    (i_op),
      .i_Ra    (i_Ra),
      .i_Rb    (i_Rb),
      .i_kill  (i_kill),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_Rc    (o_Rc),
      .o_Z     (o_Z),
      .o_busy  (o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] rc;
      logic        z;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: plain 64-bit arithmetic straight from the RV32M definitions.
   function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge i_clk);
      i_valid = 1'b1;
      i_op = op;
      i_Ra = a;
      i_Rb = b;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_Ra = $urandom;
      i_Rb = $urandom;
      i_op = 3'($urandom);
   endtask

   // lat = index of the first edge (after the accept edge) that sees o_valid high
   task automatic wait_result(output int lat, output logic [31:0] rc, output logic z);
      lat = 1;
      @(negedge i_clk);
      while (!o_valid && lat < 100) begin
         @(posedge i_clk);
         lat++;
         @(negedge i_clk);
      end
      if (!o_valid) begin
         n_total++;
         $display("FAIL timeout: o_valid still 0 after %0d edges, required 1", lat);
      end
      rc = o_Rc;
      z = o_Z;
   endtask

   task automatic consume();
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output logic [31:0] rc,
                         output logic z);
      issue(op, a, b);
      wait_result(lat, rc, z);
      consume();
   endtask

   initial begin
      int          lat;
      logic [31:0] rc, exp;
      logic        z;
      int          seen;

      vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33};
      vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33};
      vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33};
      vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33};
      vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33};
      vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33};
      vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       1'b0, 33};
      vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        1'b0, 33};
      vecs[8]  = '{3'd7, 32'd14,       32'd7,        32'd0,        1'b1, 33};
      vecs[9]  = '{3'd5, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b0, 1};
      vecs[10] = '{3'd7, 32'd100,      32'd0,        32'd100,      1'b0, 1};
      vecs[11] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1};
      vecs[12] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1, 1};
      vecs[13] = '{3'd0, 32'd0,        32'h12345,    32'd0,        1'b1, 33};

      // reset state
      #12;
      check("reset_valid", 64'(o_valid), 64'd0);
      check("reset_ready", 64'(o_ready), 64'd1);
      check("reset_rc", 64'(o_Rc), 64'd0);
      check("reset_busy", 64'(o_busy), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // table vectors
      for (int i = 0; i < 14; i++) begin
         run_op("vec", vecs[i].op, vecs[i].a, vecs[i].b, lat, rc, z);
         check($sformatf("vec%0d_rc", i), 64'(rc), 64'(vecs[i].rc));
         check($sformatf("vec%0d_z", i), 64'(z), 64'(vecs[i].z));
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      end

      // random ops against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom);
         a = pick();
         b = pick();
         run_op("rnd", op, a, b, lat, rc, z);
         exp = ref_op(op, a, b);
         check($sformatf("rnd%0d_op%0d_%h_%h_rc", i, op, a, b), 64'(rc), 64'(exp));
         check($sformatf("rnd%0d_z", i), 64'(z), 64'(exp == 0));
         check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(ref_lat(op, a, b)));
      end

      // backpressure: hold result for 10 cycles
      issue(3'd5, 32'd100, 32'd7);
      wait_result(lat, rc, z);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("bp%0d_valid", i), 64'(o_valid), 64'd1);
         check($sformatf("bp%0d_rc", i), 64'(o_Rc), 64'd14);
         check($sformatf("bp%0d_z", i), 64'(o_Z), 64'd0);
         check($sformatf("bp%0d_ready", i), 64'(o_ready), 64'd0);
         @(negedge i_clk);
      end
      consume();
      check("bp_after_valid", 64'(o_valid), 64'd0);
      check("bp_after_ready", 64'(o_ready), 64'd1);

      // kill at CALC iteration 5
      issue(3'd0, 32'h12345678, 32'h9ABCDEF1);
      repeat (4) @(posedge i_clk);
      @(negedge i_clk);
      i_kill = 1'b1;
      @(posedge i_clk);
      #1;
      i_kill = 1'b0;
      check("kcalc_busy", 64'(o_busy), 64'd0);
      check("kcalc_ready", 64'(o_ready), 64'd1);
      seen = 0;
      repeat (40) begin
         @(negedge i_clk);
         if (o_valid) seen++;
      end
      check("kcalc_no_valid", 64'(seen), 64'd0);
      run_op("kcalc_next", 3'd5, 32'd9, 32'd3, lat, rc, z);
      check("kcalc_next_rc", 64'(rc), 64'd3);

      // kill while DONE
      issue(3'd0, 32'd5, 32'd6);
      wait_result(lat, rc, z);
      check("kdone_pre_rc", 64'(rc), 64'd30);
      i_kill = 1'b1;
      @(posedge i_clk);
      #1;
      i_kill = 1'b0;
      check("kdone_valid", 64'(o_valid), 64'd0);
      check("kdone_ready", 64'(o_ready), 64'd1);
      run_op("kdone_next", 3'd5, 32'd9, 32'd3, lat, rc, z);
      check("kdone_next_rc", 64'(rc), 64'd3);
      check("kdone_next_lat", 64'(lat), 64'd33);

      // async reset mid-CALC, between edges
      issue(3'd0, 32'hDEADBEEF, 32'h1234);
      repeat (10) @(posedge i_clk);
      #3;
      i_rst = 1'b1;
      #1;
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_ready", 64'(o_ready), 64'd1);
      check("rst_rc", 64'(o_Rc), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      #1;
      i_rst = 1'b0;
      run_op("rst_next", 3'd0, 32'd3, 32'd4, lat, rc, z);
      check("rst_next_rc", 64'(rc), 64'd12);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
